// File: rtl/clkdiv_pkg.sv
// Shared defaults and helpers for the multi-channel clock-enable divider.
// Optional feature macro used by this slice: CLKDIV_SYNC_EN.
package clkdiv_pkg;

  localparam int          CW_DEF       = 27;
  localparam logic [26:0] DEF_HALF_DEF = 27'd16777216;

  // Channel-select width; a single channel still needs a 1-bit select.
  function automatic int chwOf(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: counter, live and shadow half-period, output level and tick.
// With CLKDIV_SYNC_EN defined, a sync input realigns the channel and applies any pending shadow.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int            CW       = CW_DEF,
  parameter logic [CW-1:0] DEF_HALF = CW'(DEF_HALF_DEF)
) (
  input  logic          clk,
  input  logic          clr,
`ifdef CLKDIV_SYNC_EN
  input  logic          sync,
`endif
  input  logic          en,
  input  logic          load,
  input  logic [CW-1:0] load_half,
  output logic          pending,
  output logic          clk_out,
  output logic          tick
);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_half;
  logic [CW-1:0] r_shadow;
  logic          r_pending;
  logic          r_clkOut;
  logic          r_tick;
  logic          r_wasStopped;

  logic [CW-1:0] w_cntEff;
  logic          w_boundary;

  // The counter holds while stopped, but the first enabled cycle counts from zero.
  assign w_cntEff   = r_wasStopped ? '0 : r_cnt;
  assign w_boundary = (w_cntEff == (r_half - CW'(1)));

  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt        <= '0;
      r_half       <= DEF_HALF;
      r_shadow     <= '0;
      r_pending    <= 1'b0;
      r_clkOut     <= 1'b0;
      r_tick       <= 1'b0;
      r_wasStopped <= 1'b0;
    end
`ifdef CLKDIV_SYNC_EN
    else if (sync) begin
      r_cnt        <= '0;
      r_clkOut     <= 1'b0;
      r_tick       <= 1'b0;
      r_wasStopped <= ~en;
      if (r_pending) begin
        r_half    <= r_shadow;
        r_pending <= 1'b0;
      end
      if (load) begin
        r_shadow  <= load_half;
        r_pending <= 1'b1;
      end
    end
`endif
    else begin
      r_wasStopped <= ~en;
      if (!en) begin
        r_tick <= 1'b0;
        if (r_pending) begin
          r_half    <= r_shadow;
          r_pending <= 1'b0;
          r_cnt     <= '0;
        end
      end else if (r_half == '0) begin
        r_cnt    <= '0;
        r_clkOut <= 1'b0;
        r_tick   <= 1'b0;
        if (r_pending) begin
          r_half    <= r_shadow;
          r_pending <= 1'b0;
        end
      end else if (w_boundary) begin
        r_cnt    <= '0;
        r_clkOut <= ~r_clkOut;
        r_tick   <= ~r_clkOut;
        if (r_pending) begin
          r_half    <= r_shadow;
          r_pending <= 1'b0;
        end
      end else begin
        r_cnt  <= w_cntEff + CW'(1);
        r_tick <= 1'b0;
      end
      // Loads only arrive while nothing is pending, so they never collide with an apply.
      if (load) begin
        r_shadow  <= load_half;
        r_pending <= 1'b1;
      end
    end
  end

  assign pending = r_pending;
  assign clk_out = r_clkOut;
  assign tick    = r_tick;

endmodule

// File: rtl/clkdiv_multi.sv
// NCH independent programmable square-wave enables with per-period ticks and shadowed writes.
// Optional macro CLKDIV_SYNC_EN adds a sync input that phase-aligns all channels.
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int            NCH      = 3,
  parameter int            CW       = CW_DEF,
  parameter logic [CW-1:0] DEF_HALF = CW'(DEF_HALF_DEF),
  localparam int           CHW      = chwOf(NCH)
) (
  input  logic           clk,
  input  logic           clr,
`ifdef CLKDIV_SYNC_EN
  input  logic           sync,
`endif
  input  logic [NCH-1:0] en,
  input  logic           wr_en,
  input  logic [CHW-1:0] wr_ch,
  input  logic [CW-1:0]  wr_half,
  output logic           wr_ready,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick
);

  logic [NCH-1:0]      w_pending;
  logic [NCH-1:0]      w_load;
  logic [2**CHW-1:0]   w_pendPad;
  logic                w_inRange;

  // Padding the pending vector keeps an out-of-range select from indexing past the channels.
  always_comb begin
    w_pendPad          = '0;
    w_pendPad[NCH-1:0] = w_pending;
  end

  assign w_inRange = (int'(wr_ch) < NCH);
  assign wr_ready  = w_inRange && !w_pendPad[wr_ch];

  for (genvar g = 0; g < NCH; g++) begin : gChan
    assign w_load[g] = wr_en && wr_ready && (int'(wr_ch) == g);

    clkdiv_chan #(
      .CW       (CW),
      .DEF_HALF (DEF_HALF)
    ) uChan (
      .clk       (clk),
      .clr       (clr),
`ifdef CLKDIV_SYNC_EN
      .sync      (sync),
`endif
      .en        (en[g]),
      .load      (w_load[g]),
      .load_half (wr_half),
      .pending   (w_pending[g]),
      .clk_out   (clk_out[g]),
      .tick      (tick[g])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Self-checking bench for clkdiv_multi (NCH=3, DEF_HALF=4) with a per-cycle expected-output scoreboard.
// Exercises the sync input as well when CLKDIV_SYNC_EN is defined.
module tb_clkdiv_multi;

  localparam int NCH = 3;
  localparam int CW  = 27;
  localparam int H0  = 4;

  logic           clk = 1'b0;
  logic           clr;
  logic [NCH-1:0] en;
  logic           wr_en;
  logic [1:0]     wr_ch;
  logic [CW-1:0]  wr_half;
  logic           wr_ready;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
`ifdef CLKDIV_SYNC_EN
  logic           sync;
`endif

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;

  int mCnt[NCH];
  int mHalf[NCH];
  int mShadow[NCH];
  bit mPend[NCH];
  bit mOut[NCH];
  bit mTick[NCH];

  logic [2*NCH-1:0] expQ[$];

  clkdiv_multi #(
    .NCH      (NCH),
    .CW       (CW),
    .DEF_HALF (27'd4)
  ) dut (
    .clk      (clk),
    .clr      (clr),
`ifdef CLKDIV_SYNC_EN
    .sync     (sync),
`endif
    .en       (en),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_half  (wr_half),
    .wr_ready (wr_ready),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s cyc=%0d got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit modelReady(input int ch);
    if (ch >= NCH) return 1'b0;
    return !mPend[ch];
  endfunction

  // Spec-level reference: a stopped channel is modelled as sitting at cnt=0.
  task automatic modelStep(input logic [NCH-1:0] e, input bit we, input int wc,
                           input int wh, input bit c, input bit s);
    bit acc;
    bit apply;
    if (c) begin
      for (int i = 0; i < NCH; i++) begin
        mCnt[i] = 0; mOut[i] = 0; mTick[i] = 0;
        mHalf[i] = H0; mShadow[i] = 0; mPend[i] = 0;
      end
      return;
    end
    for (int i = 0; i < NCH; i++) begin
      acc   = we && (wc == i) && !mPend[i];
      apply = 1'b0;
      if (s) begin
        mCnt[i] = 0; mOut[i] = 0; mTick[i] = 0; apply = mPend[i];
      end else if (!e[i]) begin
        mTick[i] = 0; mCnt[i] = 0; apply = mPend[i];
      end else if (mHalf[i] == 0) begin
        mCnt[i] = 0; mOut[i] = 0; mTick[i] = 0; apply = mPend[i];
      end else if (mCnt[i] == mHalf[i] - 1) begin
        mCnt[i] = 0; mTick[i] = !mOut[i]; mOut[i] = !mOut[i]; apply = mPend[i];
      end else begin
        mCnt[i]++; mTick[i] = 0;
      end
      if (apply) begin
        mHalf[i] = mShadow[i]; mPend[i] = 0;
      end
      if (acc) begin
        mShadow[i] = wh; mPend[i] = 1;
      end
    end
  endtask

  function automatic logic [2*NCH-1:0] packModel();
    logic [2*NCH-1:0] v;
    for (int i = 0; i < NCH; i++) begin
      v[NCH+i] = mOut[i];
      v[i]     = mTick[i];
    end
    return v;
  endfunction

  // Drives one cycle of inputs, queues the expected outputs, and checks them after the edge.
  task automatic applyStimulus(input logic [NCH-1:0] e, input logic we, input logic [1:0] wc,
                               input logic [CW-1:0] wh, input logic c, input logic s);
    en      = e;
    wr_en   = we;
    wr_ch   = wc;
    wr_half = wh;
    clr     = c;
`ifdef CLKDIV_SYNC_EN
    sync    = s;
`endif
    #1;
    checkOutput("wr_ready", {31'd0, wr_ready}, {31'd0, modelReady(int'(wc))});
    modelStep(e, we, int'(wc), int'(wh), c, s);
    expQ.push_back(packModel());
    @(posedge clk);
    #1;
    checkOutput("clk_out_tick", {26'd0, clk_out, tick}, {26'd0, expQ.pop_front()});
    cyc++;
  endtask

  task automatic runIdle(input int n, input logic [NCH-1:0] e);
    for (int i = 0; i < n; i++) applyStimulus(e, 1'b0, 2'd0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic expTick;
    logic expLvl;
    logic rs;
    #1;
    applyStimulus(3'b111, 1'b0, 2'd3, '0, 1'b1, 1'b0);
    applyStimulus(3'b111, 1'b0, 2'd3, '0, 1'b1, 1'b0);
    checkOutput("reset_clk_out", {29'd0, clk_out}, 32'd0);
    checkOutput("reset_tick", {29'd0, tick}, 32'd0);
    wr_en = 1'b0; wr_ch = 2'd0;
    #1;
    checkOutput("reset_ready", {31'd0, wr_ready}, 32'd1);

    // Default half of 4: rises visible in cycles 4, 12, 20 on every channel.
    for (int k = 0; k < 24; k++) begin
      applyStimulus(3'b111, 1'b0, 2'd0, '0, 1'b0, 1'b0);
      expTick = ((k + 1) == 4) || ((k + 1) == 12) || ((k + 1) == 20);
      expLvl  = (((k + 1) / 4) % 2) == 1;
      checkOutput("t1_tick", {29'd0, tick}, {29'd0, {3{expTick}}});
      checkOutput("t1_level", {29'd0, clk_out}, {29'd0, {3{expLvl}}});
    end

    runIdle(1, 3'b111);
    applyStimulus(3'b111, 1'b1, 2'd1, 27'd2, 1'b0, 1'b0);
    applyStimulus(3'b111, 1'b1, 2'd1, 27'd7, 1'b0, 1'b0);
    applyStimulus(3'b111, 1'b1, 2'd3, 27'd1, 1'b0, 1'b0);
    runIdle(10, 3'b111);

    applyStimulus(3'b111, 1'b1, 2'd2, 27'd0, 1'b0, 1'b0);
    runIdle(12, 3'b111);
    checkOutput("t4_off_level", {31'd0, clk_out[2]}, 32'd0);
    applyStimulus(3'b111, 1'b1, 2'd2, 27'd3, 1'b0, 1'b0);
    runIdle(12, 3'b111);

    runIdle(3, 3'b111);
    runIdle(5, 3'b110);
    runIdle(12, 3'b111);

    applyStimulus(3'b111, 1'b1, 2'd0, 27'd5, 1'b0, 1'b0);
    runIdle(2, 3'b111);
    applyStimulus(3'b111, 1'b0, 2'd0, '0, 1'b1, 1'b0);
    checkOutput("t6_clr_out", {26'd0, clk_out, tick}, 32'd0);
    runIdle(12, 3'b111);

`ifdef CLKDIV_SYNC_EN
    applyStimulus(3'b111, 1'b1, 2'd1, 27'd6, 1'b0, 1'b0);
    runIdle(2, 3'b111);
    applyStimulus(3'b111, 1'b0, 2'd0, '0, 1'b0, 1'b1);
    checkOutput("t6_sync_out", {26'd0, clk_out, tick}, 32'd0);
    runIdle(16, 3'b111);
`endif

    // Random mix of enables, writes (including out-of-range channel) and rare resets.
    for (int k = 0; k < 400; k++) begin
      rs = 1'b0;
`ifdef CLKDIV_SYNC_EN
      rs = ($urandom_range(0, 39) == 0);
`endif
      applyStimulus(($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b111,
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    27'($urandom_range(0, 5)), ($urandom_range(0, 99) == 0), rs);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
